bcd_sum_display_driver: RTL

//  Downstream stage of the two-digit BCD adder. Captures its 8-bit BCD sum (tens:units) via valid/ready.

---
 rtl/bcd_sum_display_driver_if.sv | 29 ++
 rtl/bcd_sum_display_driver.sv | 130 +++++++++++++
 2 files changed

// File: rtl/bcd_sum_display_driver_if.sv
// bcd_sum_display_driver_if
//   Valid/ready channel carrying one two-digit BCD sum from the adder to the
//   display driver.
//   Signals:
//     sum_valid  upstream -> driver  sum_bcd/sum_err are valid this cycle
//     sum_ready  driver -> upstream  driver can accept a new sum
//     sum_bcd    upstream -> driver  [7:4] tens digit, [3:0] units digit
//     sum_err    upstream -> driver  upstream operand error
//   Modports: master = adder side, slave = display driver side.
interface bcd_sum_display_driver_if;
  logic       sum_valid;
  logic       sum_ready;
  logic [7:0] sum_bcd;
  logic       sum_err;

  modport master (
    output sum_valid,
    output sum_bcd,
    output sum_err,
    input  sum_ready
  );

  modport slave (
    input  sum_valid,
    input  sum_bcd,
    input  sum_err,
    output sum_ready
  );
endinterface

// File: rtl/bcd_sum_display_driver.sv
// bcd_sum_display_driver
//   Captures a two-digit BCD sum over a valid/ready channel and time-multiplexes
//   the units and tens digits onto one shared active-high 7-segment bus.
//   Malformed sums (upstream error, tens > 1, units > 9) are shown as "E".
//   Ports:
//     clk   in   single clock, rising edge
//     rst   in   synchronous active-high reset
//     sum   slave modport of bcd_sum_display_driver_if (valid/ready sum input)
//     seg   out  {g,f,e,d,c,b,a}, 1 = segment lit
//     an    out  one-hot digit enable: 01 = units, 10 = tens, 00 = dark
//     err   out  displayed value is an error
//   Parameter REFRESH_DIV (>= 2): cycles each digit is driven.
//   Optional macro LEADING_ZERO_BLANK_EN: blanks a zero tens digit.
module bcd_sum_display_driver #(
  parameter int REFRESH_DIV = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  bcd_sum_display_driver_if.slave        sum,
  output logic [6:0]                     seg,
  output logic [1:0]                     an,
  output logic                           err
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {UNITS, TENS} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       disp;
  logic             disp_err;
  logic [7:0]       shadow;
  logic             shadow_err;
  logic             pending;
  logic [6:0]       seg_next;
  logic [1:0]       an_next;
  logic             wrap;
  logic             transfer;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h00;
    endcase
  endfunction

  // Only one sum can wait in the shadow register; ready drops until the
  // next refresh wrap moves it onto the display.
  assign sum.sum_ready = !pending;
  assign transfer      = sum.sum_valid && !pending;
  assign wrap          = (cnt == CNT_W'(REFRESH_DIV - 1));

  // Digit-phase state register.
  always_ff @(posedge clk) begin
    if (rst) state <= UNITS;
    else     state <= state_next;
  end

  // Phase sequencing and the segment/anode pattern for the current phase.
  always_comb begin
    state_next = state;
    seg_next   = 7'h00;
    an_next    = 2'b00;
    if (wrap) state_next = (state == UNITS) ? TENS : UNITS;
    case (state)
      UNITS: begin
        an_next  = 2'b01;
        seg_next = disp_err ? 7'h79 : enc(disp[3:0]);
      end
      TENS: begin
        an_next  = 2'b10;
        seg_next = disp_err ? 7'h00 : enc(disp[7:4]);
`ifdef LEADING_ZERO_BLANK_EN
        if (!disp_err && disp[7:4] == 4'd0) begin
          an_next  = 2'b00;
          seg_next = 7'h00;
        end
`endif
      end
      default: begin
        an_next  = 2'b00;
        seg_next = 7'h00;
      end
    endcase
  end

  // Refresh counter, capture/apply of sums and registered display outputs.
  // A sum captured on a wrap edge is held until the following wrap, since
  // the wrap branch only sees the pending flag from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      disp       <= 8'h00;
      disp_err   <= 1'b0;
      shadow     <= 8'h00;
      shadow_err <= 1'b0;
      pending    <= 1'b0;
      seg        <= 7'h00;
      an         <= 2'b00;
      err        <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap && pending) begin
        disp     <= shadow;
        disp_err <= shadow_err;
        pending  <= 1'b0;
      end
      if (transfer) begin
        shadow     <= sum.sum_bcd;
        shadow_err <= sum.sum_err | (sum.sum_bcd[7:4] > 4'd1) |
                      (sum.sum_bcd[3:0] > 4'd9);
        pending    <= 1'b1;
      end
      seg <= seg_next;
      an  <= an_next;
      err <= disp_err;
    end
  end

endmodule
